// File: rtl/adf4030_pkg.sv
// -----------------------------------------------------------------------------
// adf4030_pkg
// Shared types and default widths for the ADF4030 trigger-burst sequencer.
//   trig_seq_state_t     : 3-bit sequencer state encoding.
//   DEF_COUNT_WIDTH      : default width of pulse count / pulse index.
//   DEF_DELAY_WIDTH      : default width of anchor-to-pulse delay.
//   DEF_PW_WIDTH         : default width of pulse width and period settings.
// -----------------------------------------------------------------------------
package adf4030_pkg;

    localparam int DEF_COUNT_WIDTH = 16;
    localparam int DEF_DELAY_WIDTH = 16;
    localparam int DEF_PW_WIDTH    = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_DELAY = 3'd2,
        ST_PULSE = 3'd3,
        ST_GAP   = 3'd4,
        ST_DONE  = 3'd5
    } trig_seq_state_t;

endpackage

// File: rtl/adf4030_sysref_counter.sv
// -----------------------------------------------------------------------------
// adf4030_sysref_counter
// SYSREF rising-edge detector plus the edge counter that spaces pulse anchors.
// Ports:
//   clk, rstn    : device clock, async active-low reset
//   sysref       : SYSREF/BSYNC level already in the clk domain
//   clear        : hold the edge counter at zero (idle / arming)
//   count_en     : count detected edges (sequence running past the first anchor)
//   window       : edges counted now land while a pulse is still being serviced
//   limit        : effective period P (never zero)
//   clear_ovr    : clear the sticky overrun flag (accepted start)
//   sysref_edge  : combinational rising-edge strobe (s1 & ~s2)
//   slot_hit     : this edge completes a period of P counted edges
//   overrun      : sticky, a completed period fell inside the service window
// -----------------------------------------------------------------------------
module adf4030_sysref_counter
    import adf4030_pkg::*;
#(
    parameter int PW_WIDTH = DEF_PW_WIDTH
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                sysref,
    input  logic                clear,
    input  logic                count_en,
    input  logic                window,
    input  logic [PW_WIDTH-1:0] limit,
    input  logic                clear_ovr,
    output logic                sysref_edge,
    output logic                slot_hit,
    output logic                overrun
);

    logic                s1;
    logic                s2;
    logic [PW_WIDTH-1:0] edge_cnt;
    logic [PW_WIDTH-1:0] limit_m1;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= sysref;
            s2 <= s1;
        end
    end

    assign sysref_edge = s1 & ~s2;
    assign limit_m1    = limit - PW_WIDTH'(1);

    // The compare happens before the increment, so the counter tops out at
    // limit-1 and wraps to zero on the hit instead of overflowing.
    assign slot_hit = count_en & sysref_edge & (edge_cnt == limit_m1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            edge_cnt <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
        end else if (count_en && sysref_edge) begin
            edge_cnt <= slot_hit ? '0 : edge_cnt + PW_WIDTH'(1);
        end
    end

    // A hit while the previous pulse is still delaying or high means that
    // anchor cannot be used; the slot is dropped and flagged.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun <= 1'b0;
        end else if (clear_ovr) begin
            overrun <= 1'b0;
        end else if (slot_hit && window) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: rtl/adf4030_trig_sequencer.sv
// -----------------------------------------------------------------------------
// adf4030_trig_sequencer
// Emits a SYSREF-locked burst of N trigger pulses: wait for a SYSREF edge,
// then one pulse every P edges, each delayed cfg_delay clocks from its anchor
// edge detect and held max(cfg_width,1) clocks.
// Ports:
//   clk, rstn     : device clock, async active-low reset
//   sysref        : SYSREF/BSYNC level in the clk domain
//   start, abort  : single-cycle request strobes
//   cfg_count     : pulse count N (0 completes immediately)
//   cfg_period    : SYSREF edges between anchors P (0 treated as 1)
//   cfg_delay     : clocks from anchor edge detect to trigger rise
//   cfg_width     : trigger high time in clocks (0 treated as 1)
//   trigger       : registered trigger pulse train
//   busy          : sequence in progress
//   done          : one-cycle completion pulse
//   pulse_index   : pulses emitted in the current / last sequence
//   overrun       : sticky lost-anchor flag, cleared by an accepted start
//
// Request semantics: start and abort are sampled every clock with no
// handshake. start is accepted only in IDLE and only when abort is low in the
// same cycle; abort is honoured in every non-IDLE state and returns to IDLE
// on the next clock. The cfg_* inputs only matter on the accepting clock.
// -----------------------------------------------------------------------------
module adf4030_trig_sequencer
    import adf4030_pkg::*;
#(
    parameter int COUNT_WIDTH = DEF_COUNT_WIDTH,
    parameter int DELAY_WIDTH = DEF_DELAY_WIDTH,
    parameter int PW_WIDTH    = DEF_PW_WIDTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   sysref,
    input  logic                   start,
    input  logic                   abort,
    input  logic [COUNT_WIDTH-1:0] cfg_count,
    input  logic [PW_WIDTH-1:0]    cfg_period,
    input  logic [DELAY_WIDTH-1:0] cfg_delay,
    input  logic [PW_WIDTH-1:0]    cfg_width,
    output logic                   trigger,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] pulse_index,
    output logic                   overrun
);

    trig_seq_state_t        state;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [PW_WIDTH-1:0]    period_q;
    logic [PW_WIDTH-1:0]    width_q;
    logic [DELAY_WIDTH-1:0] delay_q;
    logic [DELAY_WIDTH-1:0] dly_cnt;
    logic [PW_WIDTH-1:0]    wid_cnt;

    logic                   sysref_edge;
    logic                   slot_hit;
    logic                   start_ok;
    logic                   cnt_clear;
    logic                   cnt_en;
    logic                   in_window;
    logic [COUNT_WIDTH-1:0] idx_next;
    logic [PW_WIDTH-1:0]    width_m1;

    assign start_ok  = (state == ST_IDLE) && start && !abort;
    assign cnt_clear = (state == ST_IDLE) || (state == ST_ARM);
    assign in_window = (state == ST_DELAY) || (state == ST_PULSE);
    assign cnt_en    = in_window || (state == ST_GAP);
    assign idx_next  = pulse_index + COUNT_WIDTH'(1);
    assign width_m1  = width_q - PW_WIDTH'(1);

    adf4030_sysref_counter #(
        .PW_WIDTH (PW_WIDTH)
    ) u_sysref_counter (
        .clk         (clk),
        .rstn        (rstn),
        .sysref      (sysref),
        .clear       (cnt_clear),
        .count_en    (cnt_en),
        .window      (in_window),
        .limit       (period_q),
        .clear_ovr   (start_ok),
        .sysref_edge (sysref_edge),
        .slot_hit    (slot_hit),
        .overrun     (overrun)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            count_q     <= '0;
            period_q    <= PW_WIDTH'(1);
            width_q     <= PW_WIDTH'(1);
            delay_q     <= '0;
            dly_cnt     <= '0;
            wid_cnt     <= '0;
            trigger     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pulse_index <= '0;
        end else if (abort && (state != ST_IDLE)) begin
            // pulse_index deliberately keeps its value so software can see
            // how far the burst got.
            state   <= ST_IDLE;
            trigger <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        count_q     <= cfg_count;
                        delay_q     <= cfg_delay;
                        period_q    <= (cfg_period == '0) ? PW_WIDTH'(1) : cfg_period;
                        width_q     <= (cfg_width == '0) ? PW_WIDTH'(1) : cfg_width;
                        pulse_index <= '0;
                        dly_cnt     <= '0;
                        wid_cnt     <= '0;
                        busy        <= 1'b1;
                        if (cfg_count == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_ARM;
                        end
                    end
                end
                ST_ARM: begin
                    if (sysref_edge) begin
                        state   <= ST_DELAY;
                        dly_cnt <= '0;
                    end
                end
                ST_DELAY: begin
                    // Delay counter starts at zero on entry, so a zero delay
                    // still spends one clock here; that clock is part of the
                    // fixed two-clock anchor latency.
                    if (dly_cnt == delay_q) begin
                        state   <= ST_PULSE;
                        trigger <= 1'b1;
                        wid_cnt <= '0;
                    end else begin
                        dly_cnt <= dly_cnt + DELAY_WIDTH'(1);
                    end
                end
                ST_PULSE: begin
                    if (wid_cnt == width_m1) begin
                        trigger     <= 1'b0;
                        pulse_index <= idx_next;
                        if (idx_next == count_q) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_GAP;
                        end
                    end else begin
                        wid_cnt <= wid_cnt + PW_WIDTH'(1);
                    end
                end
                ST_GAP: begin
                    if (slot_hit) begin
                        state   <= ST_DELAY;
                        dly_cnt <= '0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= ST_IDLE;
                    trigger <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
